// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int WEIGHT_MAX_W = 32;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero weight still earns one transaction per reload.
  function automatic logic [WEIGHT_MAX_W-1:0] weight_eff(input logic [WEIGHT_MAX_W-1:0] w);
    return (w == '0) ? {{(WEIGHT_MAX_W-1){1'b0}}, 1'b1} : w;
  endfunction

endpackage

// File: rtl/wrr_arb_rot_pri.sv
// Rotating-priority pick: lowest set bit at or above ptr, else lowest set bit overall.
module rot_pri
  import wrr_arb_pkg::*;
#(
  parameter  int W  = 4,
  localparam int IW = idx_width(W)
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [W-1:0]  mask;
  logic [W-1:0]  masked;
  logic [IW-1:0] idx_m;
  logic [IW-1:0] idx_u;
  logic          any_m;

  // Masked and unmasked lowest-index searches, masked one wins when non-empty.
  always_comb begin
    mask  = '0;
    idx_m = '0;
    idx_u = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = req & mask;
    for (int i = W - 1; i >= 0; i--) begin
      idx_m = masked[i] ? IW'(i) : idx_m;
      idx_u = req[i]    ? IW'(i) : idx_u;
    end
    any_m  = |masked;
    any    = |req;
    idx    = any_m ? idx_m : idx_u;
    onehot = any ? (W'(1) << idx) : '0;
  end

endmodule

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: one credit per transaction, grant locked until last-beat ack.
module wrr_arb
  import wrr_arb_pkg::*;
#(
  parameter  int W        = 4,
  parameter  int WEIGHT_W = 4,
  localparam int IW       = idx_width(W)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [W-1:0]          i_req,
  input  logic                  i_last,
  input  logic                  i_ack,
  input  logic [W*WEIGHT_W-1:0] i_weight,
  output logic [W-1:0]          o_gnt,
  output logic [IW-1:0]         o_gnt_enc,
  output logic                  o_gnt_vld,
  output logic                  o_locked
);

  state_t              state, state_nx;
  logic [IW-1:0]       ptr, ptr_nx;
  logic [IW-1:0]       held, held_nx;
  logic [WEIGHT_W-1:0] credit    [W];
  logic [WEIGHT_W-1:0] credit_nx [W];

  logic [W-1:0]        elig;
  logic [W-1:0]        pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [IW-1:0]       gnt_idx;
  logic                accept;
  logic                retire;
  logic [WEIGHT_W-1:0] dec;

  always_comb begin
    elig = '0;
    for (int i = 0; i < W; i++) begin
      elig[i] = i_req[i] & (credit[i] != '0);
    end
  end

  rot_pri #(.W(W)) u_pick (
    .req    (elig),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Grant outputs; a lock keeps showing its owner even while its request is dropped.
  always_comb begin
    gnt_idx = (state == LOCKED) ? held : pick_idx;
    if (srst) begin
      o_gnt     = '0;
      o_gnt_vld = 1'b0;
      o_locked  = 1'b0;
    end else if (state == LOCKED) begin
      o_gnt     = W'(1) << held;
      o_gnt_vld = i_req[held];
      o_locked  = 1'b1;
    end else begin
      o_gnt     = pick_oh;
      o_gnt_vld = pick_any;
      o_locked  = 1'b0;
    end
    o_gnt_enc = o_gnt_vld ? gnt_idx : '0;
  end

  // Next-state: lock, retire (credit/ptr update) or reload.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    held_nx  = held;
    for (int i = 0; i < W; i++) begin
      credit_nx[i] = credit[i];
    end
    accept = o_gnt_vld & i_ack;
    retire = accept & i_last;
    dec    = (credit[gnt_idx] != '0) ? credit[gnt_idx] - WEIGHT_W'(1) : '0;
    case (state)
      IDLE: begin
        if (accept && !i_last) begin
          state_nx = LOCKED;
          held_nx  = pick_idx;
        end else if ((|i_req) && !pick_any) begin
          for (int i = 0; i < W; i++) begin
            credit_nx[i] = WEIGHT_W'(weight_eff(WEIGHT_MAX_W'(i_weight[i*WEIGHT_W +: WEIGHT_W])));
          end
        end else begin
          state_nx = IDLE;
        end
      end
      LOCKED: begin
        state_nx = retire ? IDLE : LOCKED;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (retire) begin
      credit_nx[gnt_idx] = dec;
      if (dec != '0) begin
        ptr_nx = gnt_idx;
      end else begin
        ptr_nx = (gnt_idx == IW'(W - 1)) ? '0 : gnt_idx + IW'(1);
      end
    end else begin
      ptr_nx = ptr;
    end
  end

  // State, pointer and credit registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
      ptr   <= '0;
      held  <= '0;
      for (int i = 0; i < W; i++) begin
        credit[i] <= '0;
      end
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      held  <= held_nx;
      for (int i = 0; i < W; i++) begin
        credit[i] <= credit_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_wrr_arb.sv
// Directed bench for wrr_arb: a W=4 instance and a non-power-of-2 W=3 instance.
module tb_wrr_arb;

  logic        clk;
  logic        srst;
  logic        last;
  logic        ack;

  logic [3:0]  req4;
  logic [15:0] weight4;
  logic [3:0]  gnt4;
  logic [1:0]  enc4;
  logic        vld4;
  logic        locked4;

  logic [2:0]  req3;
  logic [11:0] weight3;
  logic [2:0]  gnt3;
  logic [1:0]  enc3;
  logic        vld3;
  logic        locked3;

  int errors;
  int checks;

  wrr_arb #(.W(4), .WEIGHT_W(4)) dut4 (
    .clk(clk), .srst(srst), .i_req(req4), .i_last(last), .i_ack(ack),
    .i_weight(weight4), .o_gnt(gnt4), .o_gnt_enc(enc4), .o_gnt_vld(vld4), .o_locked(locked4)
  );

  wrr_arb #(.W(3), .WEIGHT_W(4)) dut3 (
    .clk(clk), .srst(srst), .i_req(req3), .i_last(last), .i_ack(ack),
    .i_weight(weight3), .o_gnt(gnt3), .o_gnt_enc(enc3), .o_gnt_vld(vld3), .o_locked(locked3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    req4 = 4'b0000;
    req3 = 3'b000;
    ack  = 1'b0;
    last = 1'b0;
    tick();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    req4 = 4'b1111;
    req3 = 3'b111;
    ack  = 1'b1;
    last = 1'b1;
    #1;
    checks++;
    if (gnt4 !== 4'b0000 || vld4 !== 1'b0 || locked4 !== 1'b0 || enc4 !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b vld=%b locked=%b enc=%0d, expected all zero", gnt4, vld4, locked4, enc4);
    end
    tick();
    srst = 1'b0;
    ack  = 1'b0;
    #1;
    checks++;
    if (vld4 !== 1'b0 || gnt4 !== 4'b0000) begin
      errors++;
      $display("FAIL reset_credit_empty: vld=%b gnt=%b, expected bubble after reset", vld4, gnt4);
    end
    tick();
  endtask

  task automatic test_weights();
    int exp_seq[16];
    exp_seq = '{-1, 0, 1, 1, 2, 3, 3, 3, -1, 0, 1, 1, 2, 3, 3, 3};
    do_reset();
    weight4 = {4'd3, 4'd1, 4'd2, 4'd1};
    for (int c = 0; c < 16; c++) begin
      req4 = 4'b1111;
      ack  = 1'b1;
      last = 1'b1;
      #1;
      checks++;
      if (exp_seq[c] < 0) begin
        if (vld4 !== 1'b0 || gnt4 !== 4'b0000) begin
          errors++;
          $display("FAIL weights cyc%0d: vld=%b gnt=%b, expected bubble", c, vld4, gnt4);
        end
      end else begin
        if (vld4 !== 1'b1 || enc4 !== 2'(exp_seq[c]) || gnt4 !== (4'b0001 << exp_seq[c])) begin
          errors++;
          $display("FAIL weights cyc%0d: vld=%b enc=%0d gnt=%b, expected grant idx %0d", c, vld4, enc4, gnt4, exp_seq[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    weight4 = 16'h1111;
    req4 = 4'b1111;
    tick();
    for (int b = 0; b < 4; b++) begin
      ack  = 1'b1;
      last = (b == 3);
      #1;
      checks++;
      if (gnt4 !== 4'b0001 || vld4 !== 1'b1 || enc4 !== 2'd0 || locked4 !== (b != 0)) begin
        errors++;
        $display("FAIL lock_beat%0d: gnt=%b vld=%b enc=%0d locked=%b, expected gnt=0001 locked=%b", b, gnt4, vld4, enc4, locked4, (b != 0));
      end
      tick();
    end
    last = 1'b1;
    #1;
    checks++;
    if (enc4 !== 2'd1 || vld4 !== 1'b1 || locked4 !== 1'b0) begin
      errors++;
      $display("FAIL lock_next: enc=%0d vld=%b locked=%b, expected enc=1 vld=1 locked=0", enc4, vld4, locked4);
    end
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    weight4 = 16'h1111;
    req4 = 4'b0100;
    tick();
    ack  = 1'b1;
    last = 1'b0;
    #1;
    checks++;
    if (enc4 !== 2'd2 || vld4 !== 1'b1) begin
      errors++;
      $display("FAIL drop_first: enc=%0d vld=%b, expected enc=2 vld=1", enc4, vld4);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      req4 = 4'b1011;
      ack  = 1'b1;
      last = 1'b1;
      #1;
      checks++;
      if (vld4 !== 1'b0 || locked4 !== 1'b1 || gnt4 !== 4'b0100 || enc4 !== 2'd0) begin
        errors++;
        $display("FAIL drop_hold%0d: vld=%b locked=%b gnt=%b enc=%0d, expected 0 1 0100 0", c, vld4, locked4, gnt4, enc4);
      end
      tick();
    end
    req4 = 4'b1111;
    #1;
    checks++;
    if (vld4 !== 1'b1 || enc4 !== 2'd2 || locked4 !== 1'b1) begin
      errors++;
      $display("FAIL drop_resume: vld=%b enc=%0d locked=%b, expected 1 2 1", vld4, enc4, locked4);
    end
    tick();
    #1;
    checks++;
    if (vld4 !== 1'b1 || enc4 !== 2'd3 || locked4 !== 1'b0) begin
      errors++;
      $display("FAIL drop_after: vld=%b enc=%0d locked=%b, expected 1 3 0", vld4, enc4, locked4);
    end
    tick();
  endtask

  task automatic test_wrap_w3();
    int exp_seq[7];
    logic [2:0] req_seq[7];
    exp_seq = '{-1, 1, 2, 0, -1, 2, 0};
    req_seq = '{3'b010, 3'b010, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101};
    do_reset();
    weight3 = 12'h111;
    for (int c = 0; c < 7; c++) begin
      req3 = req_seq[c];
      ack  = 1'b1;
      last = 1'b1;
      #1;
      checks++;
      if (exp_seq[c] < 0) begin
        if (vld3 !== 1'b0 || gnt3 !== 3'b000) begin
          errors++;
          $display("FAIL wrap cyc%0d: vld=%b gnt=%b, expected bubble", c, vld3, gnt3);
        end
      end else begin
        if (vld3 !== 1'b1 || enc3 !== 2'(exp_seq[c]) || gnt3 !== (3'b001 << exp_seq[c])) begin
          errors++;
          $display("FAIL wrap cyc%0d: vld=%b enc=%0d gnt=%b, expected grant idx %0d", c, vld3, enc3, gnt3, exp_seq[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_zero_weight();
    do_reset();
    weight4 = 16'h1101;
    for (int c = 0; c < 6; c++) begin
      req4 = 4'b0010;
      ack  = 1'b1;
      last = 1'b1;
      #1;
      checks++;
      if ((c % 2) == 0) begin
        if (vld4 !== 1'b0) begin
          errors++;
          $display("FAIL zero_weight cyc%0d: vld=%b, expected bubble", c, vld4);
        end
      end else begin
        if (vld4 !== 1'b1 || enc4 !== 2'd1 || gnt4 !== 4'b0010) begin
          errors++;
          $display("FAIL zero_weight cyc%0d: vld=%b enc=%0d gnt=%b, expected grant idx 1", c, vld4, enc4, gnt4);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    weight4 = 16'h1111;
    req4 = 4'b1000;
    tick();
    ack  = 1'b1;
    last = 1'b0;
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if (locked4 !== 1'b1 || gnt4 !== 4'b1000) begin
      errors++;
      $display("FAIL rst_lock_setup: locked=%b gnt=%b, expected 1 1000", locked4, gnt4);
    end
    tick();
    srst = 1'b1;
    req4 = 4'b1111;
    #1;
    checks++;
    if (gnt4 !== 4'b0000 || vld4 !== 1'b0 || locked4 !== 1'b0) begin
      errors++;
      $display("FAIL rst_lock_during: gnt=%b vld=%b locked=%b, expected all zero", gnt4, vld4, locked4);
    end
    tick();
    srst = 1'b0;
    ack  = 1'b1;
    last = 1'b1;
    #1;
    checks++;
    if (locked4 !== 1'b0 || vld4 !== 1'b0) begin
      errors++;
      $display("FAIL rst_lock_bubble: locked=%b vld=%b, expected 0 0", locked4, vld4);
    end
    tick();
    #1;
    checks++;
    if (vld4 !== 1'b1 || enc4 !== 2'd0 || gnt4 !== 4'b0001) begin
      errors++;
      $display("FAIL rst_lock_restart: vld=%b enc=%0d gnt=%b, expected grant idx 0", vld4, enc4, gnt4);
    end
    tick();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    srst    = 1'b1;
    req4    = 4'b0000;
    req3    = 3'b000;
    ack     = 1'b0;
    last    = 1'b0;
    weight4 = 16'h1111;
    weight3 = 12'h111;
    tick();
    test_reset();
    test_weights();
    test_lock_hold();
    test_drop();
    test_wrap_w3();
    test_zero_weight();
    test_reset_mid_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
